pc_seq: RTL and testbench

Parametrised program-counter sequencer for the processor fetch stage. Generalises the 9-bit load/increment counter: configurable address width and reset vector, signed relative branches, stall hold, and an optional return-address stack (RAS) for call/return. Drives `ins_addr` to instruction memory; takes targets from the C bus and a branch offset from the control unit.

---
 rtl/pc_pkg.sv | 16 +
 rtl/pc_ras.sv | 56 +++++
 rtl/pc_seq.sv | 111 +++++++++++
 tb/tb_pc_seq.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: operation encoding shared by the program-counter sequencer.
// Codes 6-7 are unassigned and decode as HOLD.
package pc_pkg;

    localparam int PC_OP_W = 3;

    typedef enum logic [PC_OP_W-1:0] {
        HOLD   = 3'd0,
        INC    = 3'd1,
        LOAD   = 3'd2,
        BRANCH = 3'd3,
        CALL   = 3'd4,
        RET    = 3'd5
    } pc_op_t;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address LIFO; when full a push overwrites the oldest.
// Compiled only when PC_SEQ_RAS_EN is defined.
`ifdef PC_SEQ_RAS_EN
module pc_ras
    import pc_pkg::*;
#(
    parameter int PCWIDTH   = 9,
    parameter int RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [PCWIDTH-1:0]             din,
    output logic [PCWIDTH-1:0]             dout,
    output logic [$clog2(RAS_DEPTH+1)-1:0] count,
    output logic                           full,
    output logic                           empty
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH+1);

    logic [PCWIDTH-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      ptr_inc;
    logic [PW-1:0]      ptr_dec;

    // ptr is the next write slot; when full it also names the oldest entry
    assign ptr_inc = (ptr == PW'(RAS_DEPTH-1)) ? '0 : ptr + PW'(1);
    assign ptr_dec = (ptr == '0) ? PW'(RAS_DEPTH-1) : ptr - PW'(1);

    assign dout  = mem[ptr_dec];
    assign full  = (count == CW'(RAS_DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr   <= ptr_inc;
            count <= full ? count : count + CW'(1);
        end else if (pop && !empty) begin
            ptr   <= ptr_dec;
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[ptr] <= din;
    end

endmodule
`endif

// File: rtl/pc_seq.sv
// pc_seq: fetch-stage program counter with load, increment, relative branch,
// stall hold and, under PC_SEQ_RAS_EN, a return-address stack for CALL/RET.
module pc_seq
    import pc_pkg::*;
#(
    parameter int                   PCWIDTH    = 9,
    parameter logic [PCWIDTH-1:0]   RESET_ADDR = '0,
    parameter int                   RAS_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic [PC_OP_W-1:0]             op,
    input  logic [PCWIDTH-1:0]             C_bus,
    input  logic [PCWIDTH-1:0]             offset,
    output logic [PCWIDTH-1:0]             ins_addr,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_overflow,
    output logic                           ras_underflow
);

    logic [PCWIDTH-1:0] inc_addr;
    logic [PCWIDTH-1:0] next_addr;

`ifdef PC_SEQ_RAS_EN
    logic               push;
    logic               pop;
    logic               ovf_d;
    logic               unf_d;
    logic               ras_full;
    logic               ras_empty;
    logic [PCWIDTH-1:0] ras_top;
`endif

    assign inc_addr = ins_addr + PCWIDTH'(1);

    always_comb begin
        next_addr = ins_addr;
`ifdef PC_SEQ_RAS_EN
        push  = 1'b0;
        pop   = 1'b0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
`endif
        unique case (pc_op_t'(op))
            INC:    next_addr = inc_addr;
            LOAD:   next_addr = C_bus;
            BRANCH: next_addr = ins_addr + offset;
            CALL: begin
                next_addr = C_bus;
`ifdef PC_SEQ_RAS_EN
                push  = 1'b1;
                ovf_d = ras_full;
`endif
            end
            RET: begin
`ifdef PC_SEQ_RAS_EN
                if (ras_empty) begin
                    next_addr = inc_addr;
                    unf_d     = 1'b1;
                end else begin
                    next_addr = ras_top;
                    pop       = 1'b1;
                end
`else
                next_addr = inc_addr;
`endif
            end
            default: next_addr = ins_addr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            ins_addr <= RESET_ADDR;
        else if (!stall)
            ins_addr <= next_addr;
    end

`ifdef PC_SEQ_RAS_EN
    pc_ras #(
        .PCWIDTH   (PCWIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (push && !stall),
        .pop   (pop && !stall),
        .din   (inc_addr),
        .dout  (ras_top),
        .count (ras_count),
        .full  (ras_full),
        .empty (ras_empty)
    );

    always_ff @(posedge clk) begin
        if (rst || stall) begin
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            ras_overflow  <= ovf_d;
            ras_underflow <= unf_d;
        end
    end
`else
    assign ras_count     = '0;
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed vector table plus hand-written call/return sequences.
// Expectations follow PC_SEQ_RAS_EN so either build can be checked.
module tb_pc_seq;
    import pc_pkg::*;

`ifdef PC_SEQ_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       stall;
    logic [2:0] op;
    logic [8:0] C_bus;
    logic [8:0] offset;
    logic [8:0] ins_addr;
    logic [2:0] ras_count;
    logic       ras_overflow;
    logic       ras_underflow;

    int n_run;
    int n_fail;

    pc_seq #(
        .PCWIDTH    (9),
        .RESET_ADDR (9'h010),
        .RAS_DEPTH  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .op            (op),
        .C_bus         (C_bus),
        .offset        (offset),
        .ins_addr      (ins_addr),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       s;
        logic [2:0] o;
        logic [8:0] c;
        logic [8:0] off;
        logic [8:0] ea;
        logic [2:0] ec;
        logic       eo;
        logic       eu;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic s,
                                input logic [2:0] o, input logic [8:0] c,
                                input logic [8:0] off, input logic [8:0] ea,
                                input logic [2:0] ec, input logic eo,
                                input logic eu);
        vec_t v;
        v.r = r; v.s = s; v.o = o; v.c = c; v.off = off;
        v.ea = ea; v.ec = ec; v.eo = eo; v.eu = eu;
        return v;
    endfunction

    task automatic step(input vec_t v, input string name);
        @(negedge clk);
        rst    = v.r;
        stall  = v.s;
        op     = v.o;
        C_bus  = v.c;
        offset = v.off;
        @(posedge clk);
        #1;
        n_run++;
        if (ins_addr !== v.ea || ras_count !== v.ec ||
            ras_overflow !== v.eo || ras_underflow !== v.eu) begin
            n_fail++;
            $display("FAIL %s: got addr=%h cnt=%0d ovf=%b unf=%b want addr=%h cnt=%0d ovf=%b unf=%b",
                     name, ins_addr, ras_count, ras_overflow, ras_underflow,
                     v.ea, v.ec, v.eo, v.eu);
        end
    endtask

    // returns RAS-build value when the stack exists, plain value otherwise
    function automatic logic [8:0] pa(input logic [8:0] with_ras,
                                      input logic [8:0] no_ras);
        return RAS ? with_ras : no_ras;
    endfunction

    function automatic logic [2:0] pc(input logic [2:0] c);
        return RAS ? c : 3'd0;
    endfunction

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst = 1'b1; stall = 1'b0; op = 3'd0; C_bus = '0; offset = '0;

        tbl.push_back(mk(1,0,HOLD,  9'h000,9'h000, 9'h010,0,0,0));
        tbl.push_back(mk(0,0,INC,   9'h000,9'h000, 9'h011,0,0,0));
        tbl.push_back(mk(0,0,INC,   9'h000,9'h000, 9'h012,0,0,0));
        tbl.push_back(mk(0,0,INC,   9'h000,9'h000, 9'h013,0,0,0));
        tbl.push_back(mk(0,0,LOAD,  9'h1FF,9'h000, 9'h1FF,0,0,0));
        tbl.push_back(mk(0,0,INC,   9'h000,9'h000, 9'h000,0,0,0));
        tbl.push_back(mk(0,0,BRANCH,9'h000,9'h1FE, 9'h1FE,0,0,0));
        tbl.push_back(mk(0,0,BRANCH,9'h000,9'h005, 9'h003,0,0,0));
        tbl.push_back(mk(0,0,LOAD,  9'h020,9'h000, 9'h020,0,0,0));
        tbl.push_back(mk(0,1,LOAD,  9'h100,9'h000, 9'h020,0,0,0));
        tbl.push_back(mk(0,1,LOAD,  9'h100,9'h000, 9'h020,0,0,0));
        tbl.push_back(mk(0,0,INC,   9'h100,9'h000, 9'h021,0,0,0));
        tbl.push_back(mk(0,0,3'd6,  9'h100,9'h004, 9'h021,0,0,0));
        tbl.push_back(mk(0,0,3'd7,  9'h100,9'h004, 9'h021,0,0,0));
        tbl.push_back(mk(0,0,LOAD,  9'h040,9'h000, 9'h040,0,0,0));
        tbl.push_back(mk(0,0,CALL,  9'h080,9'h000, 9'h080,pc(1),0,0));
        tbl.push_back(mk(0,0,CALL,  9'h0C0,9'h000, 9'h0C0,pc(2),0,0));
        tbl.push_back(mk(0,0,RET,   9'h000,9'h000, pa(9'h081,9'h0C1),pc(1),0,0));
        tbl.push_back(mk(0,0,RET,   9'h000,9'h000, pa(9'h041,9'h0C2),0,0,0));
        tbl.push_back(mk(0,0,LOAD,  9'h010,9'h000, 9'h010,0,0,0));
        tbl.push_back(mk(0,0,CALL,  9'h055,9'h000, 9'h055,pc(1),0,0));
        tbl.push_back(mk(0,0,RET,   9'h000,9'h000, pa(9'h011,9'h056),0,0,0));

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // overflow: fifth CALL drops the oldest return address (0x101)
        step(mk(0,0,LOAD,9'h100,0, 9'h100,0,0,0), "ovf_load");
        step(mk(0,0,CALL,9'h200,0, 9'h200,pc(1),0,0), "ovf_call1");
        step(mk(0,0,CALL,9'h300,0, 9'h300,pc(2),0,0), "ovf_call2");
        step(mk(0,0,CALL,9'h010,0, 9'h010,pc(3),0,0), "ovf_call3");
        step(mk(0,0,CALL,9'h020,0, 9'h020,pc(4),0,0), "ovf_call4");
        step(mk(0,0,CALL,9'h030,0, 9'h030,pc(4),RAS,0), "ovf_call5");
        step(mk(0,0,RET,0,0, pa(9'h021,9'h031),pc(3),0,0), "ovf_ret1");
        step(mk(0,0,RET,0,0, pa(9'h011,9'h032),pc(2),0,0), "ovf_ret2");
        step(mk(0,0,RET,0,0, pa(9'h301,9'h033),pc(1),0,0), "ovf_ret3");
        step(mk(0,0,RET,0,0, pa(9'h201,9'h034),0,0,0), "ovf_ret4");
        step(mk(0,0,RET,0,0, pa(9'h202,9'h035),0,0,RAS), "unf_ret5");
        step(mk(0,0,HOLD,0,0, pa(9'h202,9'h035),0,0,0), "unf_clear");

        // stalled CALL must not push; flags stay low under stall
        step(mk(0,0,LOAD,9'h040,0, 9'h040,0,0,0), "stl_load");
        step(mk(0,1,CALL,9'h080,0, 9'h040,0,0,0), "stl_call");
        step(mk(0,1,RET,9'h000,0, 9'h040,0,0,0), "stl_ret");
        step(mk(0,0,CALL,9'h080,0, 9'h080,pc(1),0,0), "stl_call2");
        step(mk(0,0,RET,0,0, pa(9'h041,9'h081),0,0,0), "stl_ret2");

        // reset mid-sequence empties the stack
        step(mk(0,0,CALL,9'h0A0,0, 9'h0A0,pc(1),0,0), "rst_call1");
        step(mk(0,0,CALL,9'h0B0,0, 9'h0B0,pc(2),0,0), "rst_call2");
        step(mk(1,0,CALL,9'h0C0,0, 9'h010,0,0,0), "rst_mid");
        step(mk(0,0,RET,0,0, 9'h011,0,0,RAS), "rst_ret");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
